// File: rtl/adder_sched_pkg.sv
// Shared types and arbitration helper for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int ADD_LAT = 4;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } tag_t;

  // First valid requester at or above ptr, wrapping at n-1; one-hot, zero if none.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int n);
    logic [7:0] gnt;
    logic [2:0] idx;
    gnt = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (valid[idx]) gnt = 8'(1) << idx;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Requester-id/valid shift register that tracks operations through the external adder.
module tag_delay_line
  import adder_sched_pkg::*;
#(
  parameter int LAT = ADD_LAT
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);

  // Stage 0 lines up with the registered add_* operands, stage LAT with add_sum/add_cout.
  tag_t tag_q [LAT:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k <= LAT; k++) busy_o = busy_o | tag_q[k].valid;
  end

  assign tag_o = tag_q[LAT];

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin front end sharing one external pipelined adder among NUM_REQ requesters.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = ADD_LAT,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  input  logic                     flush,
  output logic                     idle,
  output logic [31:0]              op_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [7:0]         gnt_ext;
  logic               xfer;
  logic [2:0]         gnt_id;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               sel_cin;
  logic [WIDTH-1:0]   add_a_q, add_b_q;
  logic               add_cin_q;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_cout_q;
  logic [31:0]        op_count_q;
  tag_t               tag_in, tag_out;
  logic               tags_busy;

  assign gnt_ext   = rr_pick(8'(req_valid), 3'(ptr_q), NUM_REQ);
  assign req_ready = flush ? '0 : gnt_ext[NUM_REQ-1:0];
  // A grant is only ever given to a valid requester, so any grant bit is a transfer.
  assign xfer      = ~flush & (|gnt_ext);

  always_comb begin
    gnt_id  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_id  = 3'(i);
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  assign ptr_d        = xfer ? PW'((int'(gnt_id) + 1) % NUM_REQ) : ptr_q;
  assign tag_in.valid = xfer;
  assign tag_in.id    = gnt_id;

  tag_delay_line #(.LAT(LAT)) u_tags (
    .clk    (clk),
    .reset  (reset),
    .tag_i  (tag_in),
    .tag_o  (tag_out),
    .busy_o (tags_busy)
  );

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (tag_out.valid && tag_out.id == 3'(i)) rsp_valid_d[i] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= add_sum;
      rsp_cout_q  <= add_cout;
      if (xfer) begin
        add_a_q    <= sel_a;
        add_b_q    <= sel_b;
        add_cin_q  <= sel_cin;
        op_count_q <= op_count_q + 32'd1;
      end
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign op_count  = op_count_q;
  assign idle      = ~tags_busy & ~(|rsp_valid_q) & ~xfer;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler with a behavioural 4-stage adder attached.
module tb_adder_rr_scheduler;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_cin = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           flush = 1'b0;
  logic           idle;
  logic [31:0]    op_count;

  adder_rr_scheduler #(.NUM_REQ(N), .LAT(L), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .flush(flush), .idle(idle), .op_count(op_count)
  );

  always #5 clk = ~clk;

  logic [32:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
  end
  assign {add_cout, add_sum} = apipe[L-1];

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] s;
    logic         c;
    int           edge_n;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, ecnt = 0, rsp_cnt = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] v, input logic [W-1:0] s, input logic c);
    q.push_back('{v: v, s: s, c: c, edge_n: ecnt + 2 + L});
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid != '0) begin
      exp_t e;
      rsp_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got %b expected none", rsp_valid);
      end else begin
        e = q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(e.v));
        chk("rsp_sum", 64'(rsp_sum), 64'(e.s));
        chk("rsp_cout", 64'(rsp_cout), 64'(e.c));
        chk("rsp_latency", 64'(ecnt), 64'(e.edge_n));
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] expg, input string name);
    @(negedge clk);
    req_valid = v;
    #1 chk(name, 64'(req_ready), 64'(expg));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    flush = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    #1 chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [N-1:0] mgnt(input logic [N-1:0] v, input int p, input logic f);
    if (f) return '0;
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
    return '0;
  endfunction

  logic [N-1:0] g2 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    #1;
    chk("rst_add_a", 64'(add_a), 0);
    chk("rst_add_b", 64'(add_b), 0);
    chk("rst_add_cin", 64'(add_cin), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_sum", 64'(rsp_sum), 0);
    chk("rst_rsp_cout", 64'(rsp_cout), 0);
    chk("rst_op_count", 64'(op_count), 0);
    chk("rst_idle", 64'(idle), 1);
    @(negedge clk);
    reset = 1'b0;

    // single op with carry out of bit 31
    req_a[2*W +: W] = 32'hFFFF_FFFF;
    req_b[2*W +: W] = 32'h0000_0001;
    req_cin = '0;
    drive(4'b0100, 4'b0100, "t1_gnt");
    push(4'b0100, 32'h0, 1'b1);
    drain();
    chk("t1_op_count", 64'(op_count), 1);
    chk("t1_idle", 64'(idle), 1);

    // all four contending
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(i);
      req_b[i*W +: W] = 32'd10;
    end
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, g2[k], "t2_gnt");
      push(g2[k], 32'd10 + 32'(k % 4), 1'b0);
    end
    drain();
    chk("t2_op_count", 64'(op_count), 8);

    // requester 1 streaming back-to-back
    do_reset();
    req_b[1*W +: W] = 32'd1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_a[1*W +: W] = 32'(k);
      req_valid = 4'b0010;
      #1 chk("t3_gnt", 64'(req_ready), 64'b0010);
      push(4'b0010, 32'(k + 1), 1'b0);
    end
    drain();
    chk("t3_op_count", 64'(op_count), 5);

    // flush with three in flight
    do_reset();
    req_b[0 +: W] = 32'd0;
    req_cin = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_a[0 +: W] = 32'd100 + 32'(k);
      req_valid = 4'b0001;
      #1 chk("t4_gnt", 64'(req_ready), 64'b0001);
      push(4'b0001, 32'd101 + 32'(k), 1'b0);
    end
    @(negedge clk);
    flush = 1'b1;
    #1 chk("t4_flush_ready", 64'(req_ready), 0);
    chk("t4_busy_idle", 64'(idle), 0);
    begin
      bit done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        #1;
        if (q.size() == 0 && rsp_valid != '0) begin
          chk("t4_idle_last_rsp", 64'(idle), 0);
          @(negedge clk);
          #1 chk("t4_idle_after", 64'(idle), 1);
          done = 1;
        end
      end
      if (!done) chk("t4_flush_timeout", 64'(q.size()), 0);
    end
    chk("t4_op_count", 64'(op_count), 3);
    flush = 1'b0;
    req_valid = '0;
    req_cin = '0;

    // reset while two ops are in flight
    do_reset();
    drive(4'b1000, 4'b1000, "t5_gnt0");
    push(4'b1000, 32'd0, 1'b0);
    drive(4'b1000, 4'b1000, "t5_gnt1");
    push(4'b1000, 32'd0, 1'b0);
    do_reset();
    #1 chk("t5_op_count", 64'(op_count), 0);
    chk("t5_idle", 64'(idle), 1);
    repeat (12) @(negedge clk);
    drive(4'b1111, 4'b0001, "t5_gnt_after");
    req_valid = '0;

    // random traffic against a round-robin reference model
    do_reset();
    begin
      int mptr = 0, nops = 0, rbase;
      rbase = rsp_cnt;
      for (int c = 0; c < 200; c++) begin
        logic [N-1:0] v, g;
        logic f;
        @(negedge clk);
        v = N'($urandom_range(0, 15));
        f = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < N; i++) begin
          req_a[i*W +: W] = $urandom;
          req_b[i*W +: W] = $urandom;
        end
        req_cin = N'($urandom_range(0, 15));
        req_valid = v;
        flush = f;
        g = mgnt(v, mptr, f);
        #1 chk("rnd_gnt", 64'(req_ready), 64'(g));
        for (int i = 0; i < N; i++) begin
          if (g[i]) begin
            logic [32:0] r;
            r = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]} + {32'd0, req_cin[i]};
            push(g, r[W-1:0], r[W]);
            mptr = (i + 1) % N;
            nops++;
          end
        end
      end
      flush = 1'b0;
      drain();
      chk("rnd_op_count", 64'(op_count), 64'(nops));
      chk("rnd_rsp_count", 64'(rsp_cnt - rbase), 64'(nops));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
